// File: rtl/uart_resp_tx.sv
// uart_resp_tx: response-path UART transmitter.
// Result bytes are buffered in a byte FIFO and sent on tx_o as 8N1 frames, LSB first.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data
// bits, giving 11-bit frames. The default build has no parity state or parity logic.
//
// Handshake (input side): a byte is written on the rising edge where valid_i && ready_o.
// ready_o is !full, derived only from the registered count and never from valid_i.
// While ready_o is low the source holds data_i/valid_i stable until it is accepted.
module uart_resp_tx #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [7:0]                  data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  // ST_PARITY keeps its encoding in both builds so state_q decodes the same way.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Serializer state; state_q is the FSM state observable for debug/checkers
  state_e           state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             start_frame;
  logic             baud_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign ready_o      = (count_q != CNT_FULL);
  assign push         = valid_i && ready_o;
  assign head         = mem_q[rd_ptr_q];
  assign baud_last    = (baud_q == BAUD_LAST);
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != ST_IDLE) || (count_q != '0);
  assign fifo_count_o = count_q;

  // FIFO pointer and count next-state; a blocked push never touches the count
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Byte storage; contents are don't-care after reset so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Serializer next-state: bit timing, shifting and the head-of-FIFO pop
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_IDLE;
          // Back-to-back frames: next start bit follows the stop bit directly
          if (count_q != '0) begin
            start_frame = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      shift_d = head;
      tx_d    = 1'b0;
      baud_d  = '0;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // FSM, FIFO pointers and registered line output; reset forces the line idle at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_resp_tx.sv
// Testbench for uart_resp_tx: scoreboard of pushed bytes against frames decoded
// from tx_o by a mid-bit sampling UART receiver model.
module tb_uart_resp_tx;

  localparam int CLK_FREQ_HZ = 12_000_000;
  localparam int BAUD_RATE   = 115_200;
  localparam int FIFO_DEPTH  = 16;
  localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * CPB;

  // ---------------- clock / reset ----------------
  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic [7:0] data_i  = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_o;

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  uart_resp_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  data;
    logic        start_b;
    logic        par_b;
    logic        stop_b;
    logic [31:0] t_start;
  } frame_t;

  logic [7:0] exp_q[$];
  frame_t     rx_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // ---------------- receiver model ----------------
  initial begin : rx_model
    logic             m_active;
    logic             m_prev;
    int               m_cnt;
    int               m_bit;
    logic [NBITS-1:0] m_bits;
    logic [31:0]      m_t0;
    frame_t           f;
    m_active = 1'b0;
    m_prev   = 1'b1;
    m_cnt    = 0;
    m_bits   = '0;
    m_t0     = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (m_prev && !tx_o) begin
          m_active = 1'b1;
          m_cnt    = 0;
          m_t0     = cyc;
        end
      end else begin
        m_cnt = m_cnt + 1;
        if ((m_cnt % CPB) == (CPB / 2)) begin
          m_bit         = m_cnt / CPB;
          m_bits[m_bit] = tx_o;
          if (m_bit == NBITS - 1) begin
            f.data    = m_bits[8:1];
            f.start_b = m_bits[0];
`ifdef UART_TX_PARITY_EN
            f.par_b   = m_bits[9];
`else
            f.par_b   = 1'b0;
`endif
            f.stop_b  = m_bits[NBITS-1];
            f.t_start = m_t0;
            rx_q.push_back(f);
            m_active = 1'b0;
          end
        end
      end
      m_prev = tx_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Present a byte from a falling edge and hold it until ready_o; returns just
  // before the accepting rising edge with valid_i still high.
  task automatic push_byte(input logic [7:0] b);
    int w;
    @(negedge clk_i);
    data_i  = b;
    valid_i = 1'b1;
    w = 0;
    while (!ready_o && w < 3000) begin
      @(negedge clk_i);
      w++;
    end
    n_checks++;
    if (ready_o !== 1'b1) $display("FAIL push_accept: ready_o=%b required 1 for byte %h", ready_o, b);
    else n_pass++;
    exp_q.push_back(b);
  endtask

  task automatic end_push();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int w;
    w = 0;
    while (rx_q.size() < n && w < budget) begin
      @(negedge clk_i);
      w++;
    end
    n_checks++;
    if (rx_q.size() < n) $display("FAIL rx_timeout: frames=%0d required %0d", rx_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_o && w < 25000) begin
      @(negedge clk_i);
      w++;
    end
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL idle_timeout: busy_o=%b required 0", busy_o);
    else n_pass++;
    repeat (4) @(negedge clk_i);
  endtask

  // Pop one decoded frame and one expected byte and compare them
  task automatic check_frame(input string name);
    frame_t     f;
    logic [7:0] e;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_empty: rx=%0d exp=%0d required both non-zero", name, rx_q.size(), exp_q.size());
    end else begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (f.data !== e) $display("FAIL %s_data: got %h required %h", name, f.data, e);
      else n_pass++;
      n_checks++;
      if (f.start_b !== 1'b0 || f.stop_b !== 1'b1)
        $display("FAIL %s_framing: start=%b stop=%b required 0/1", name, f.start_b, f.stop_b);
      else n_pass++;
`ifdef UART_TX_PARITY_EN
      n_checks++;
      if (f.par_b !== ^e) $display("FAIL %s_parity: got %b required %b", name, f.par_b, ^e);
      else n_pass++;
`endif
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1) $display("FAIL reset_hold_tx: got %b required 1", tx_o);
    else n_pass++;
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1) $display("FAIL reset_tx: got %b required 1", tx_o);
    else n_pass++;
    n_checks++;
    if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", ready_o);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy_o);
    else n_pass++;
    n_checks++;
    if (fifo_count_o !== 5'd0) $display("FAIL reset_count: got %0d required 0", fifo_count_o);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    push_byte(8'hEC);
    end_push();
    // one cycle after acceptance: still idle line, byte buffered
    n_checks++;
    if (tx_o !== 1'b1 || fifo_count_o !== 5'd1 || busy_o !== 1'b1)
      $display("FAIL single_accept: tx=%b count=%0d busy=%b required 1/1/1", tx_o, fifo_count_o, busy_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b0 || fifo_count_o !== 5'd0 || busy_o !== 1'b1)
      $display("FAIL single_start: tx=%b count=%0d busy=%b required 0/0/1", tx_o, fifo_count_o, busy_o);
    else n_pass++;
    repeat (FRAME_CLKS - 1) @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b1 || tx_o !== 1'b1)
      $display("FAIL single_stop_end: busy=%b tx=%b required 1/1", busy_o, tx_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1)
      $display("FAIL single_done: busy=%b tx=%b required 0/1", busy_o, tx_o);
    else n_pass++;
    wait_rx(1, 10);
    check_frame("single");
  endtask

  task automatic test_back_to_back();
    frame_t f0;
    frame_t f1;
    push_byte(8'h48);
    push_byte(8'h69);
    end_push();
    wait_rx(2, 2 * FRAME_CLKS + 200);
    if (rx_q.size() >= 2) begin
      f0 = rx_q[0];
      f1 = rx_q[1];
      n_checks++;
      if (f1.t_start - f0.t_start !== 32'(FRAME_CLKS))
        $display("FAIL b2b_gap: start delta %0d required %0d", f1.t_start - f0.t_start, FRAME_CLKS);
      else n_pass++;
      n_checks++;
      if ({f0.data, f1.data} !== 16'h4869)
        $display("FAIL b2b_text: got %h required 4869", {f0.data, f1.data});
      else n_pass++;
    end
    check_frame("b2b0");
    check_frame("b2b1");
    wait_idle();
  endtask

  task automatic test_fifo_full();
    logic [7:0] b;
    int         w;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(8'h10 + i));
    end
    // 18th byte: FIFO now holds 16 with the first byte on the line
    b = 8'hF1;
    @(negedge clk_i);
    data_i  = b;
    valid_i = 1'b1;
    n_checks++;
    if (ready_o !== 1'b0 || fifo_count_o !== 5'd16)
      $display("FAIL full_block: ready=%b count=%0d required 0/16", ready_o, fifo_count_o);
    else n_pass++;
    w = 0;
    while (!ready_o && w < 3000) begin
      @(negedge clk_i);
      w++;
    end
    n_checks++;
    if (ready_o !== 1'b1 || fifo_count_o !== 5'd15)
      $display("FAIL full_release: ready=%b count=%0d required 1/15", ready_o, fifo_count_o);
    else n_pass++;
    n_checks++;
    if (w < FRAME_CLKS - 40 || w > FRAME_CLKS)
      $display("FAIL full_wait: waited %0d cycles required about %0d", w, FRAME_CLKS - 17);
    else n_pass++;
    exp_q.push_back(b);
    end_push();
    n_checks++;
    if (fifo_count_o !== 5'd16) $display("FAIL full_refill: count=%0d required 16", fifo_count_o);
    else n_pass++;
    wait_rx(18, 18 * FRAME_CLKS + 500);
    for (int i = 0; i < 18; i++) check_frame("fifo");
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    int w;
    push_byte(8'hA5);
    end_push();
    w = 0;
    while (tx_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    repeat (499) @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b0) $display("FAIL midrst_pre: tx=%b required 0", tx_o);
    else n_pass++;
    #1;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || fifo_count_o !== 5'd0 || busy_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL midrst_async: tx=%b count=%0d busy=%b ready=%b required 1/0/0/1",
               tx_o, fifo_count_o, busy_o, ready_o);
    else n_pass++;
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (rx_q.size() != 0) $display("FAIL midrst_partial: frames=%0d required 0", rx_q.size());
    else n_pass++;
    push_byte(8'h00);
    end_push();
    wait_rx(1, FRAME_CLKS + 100);
    check_frame("midrst");
    wait_idle();
    n_checks++;
    if (rx_q.size() != 0) $display("FAIL midrst_extra: frames=%0d required 0", rx_q.size());
    else n_pass++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    frame_t f;
    int     n;
    push_byte(8'h07);
    end_push();
    n = 0;
    while (busy_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    n_checks++;
    if (n !== FRAME_CLKS + 1) $display("FAIL par_len: busy %0d cycles required %0d", n, FRAME_CLKS + 1);
    else n_pass++;
    wait_rx(1, 10);
    if (rx_q.size() > 0) begin
      f = rx_q[0];
      n_checks++;
      if (f.par_b !== 1'b1) $display("FAIL par_07: got %b required 1", f.par_b);
      else n_pass++;
    end
    check_frame("par07");
    push_byte(8'h48);
    end_push();
    wait_rx(1, FRAME_CLKS + 100);
    if (rx_q.size() > 0) begin
      f = rx_q[0];
      n_checks++;
      if (f.par_b !== 1'b0) $display("FAIL par_48: got %b required 0", f.par_b);
      else n_pass++;
    end
    check_frame("par48");
    wait_idle();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_exp: %0d bytes never received", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
